// File: rtl/lf_pkg.sv
// Shared constants and elaboration-time helpers for the Ladner-Fischer
// pipelined adder: legal parameter ranges, clog2, and the rule that decides
// after which prefix level a pipeline register sits.
package lf_pkg;

  localparam int LF_WIDTH_MIN = 2;
  localparam int LF_WIDTH_MAX = 64;
  localparam int LF_PIPE_MIN  = 1;

  // Ceiling log2 for positive n (0 for n <= 1).
  function automatic int lf_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Deepest pipeline for a given width: one register per prefix level plus
  // the register in front of the tree.
  function automatic int lf_pipe_max(input int width);
    return lf_clog2(width) + 1;
  endfunction

  // Prefix level after which internal boundary k (1..stages-1) is placed.
  function automatic int lf_boundary_level(input int k, input int levels, input int stages);
    return (k * levels) / stages;
  endfunction

  // True when some internal boundary lands right after prefix level lvl
  // (level 0 is the generate/propagate formation before the tree).
  function automatic bit lf_is_boundary(input int lvl, input int levels, input int stages);
    bit hit;
    hit = 1'b0;
    for (int k = 1; k < stages; k++) begin
      if (lf_boundary_level(k, levels, stages) == lvl) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/lf_dot.sv
// Prefix "dot" cell: merges a high (g,p) group with the adjacent lower group.
module lf_dot (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;

endmodule

// File: rtl/lf_prefix_adder_pipe.sv
// Pipelined Ladner-Fischer (minimum-depth) prefix adder.
// {cout,sum} = a + b + cin, ovf = carry into MSB ^ carry out of MSB.
// Optional feature macro LF_ADD_SUB_EN adds port sub: sub=1 computes
// a + ~b + 1 with cin ignored.
//
// Handshake: a beat moves on a clock edge when valid and ready are both high.
// The whole pipe advances together on adv = !out_valid || out_ready, and
// in_ready equals adv, so a stalled result freezes every stage and blocks
// input; bubbles travel through the stages without being squeezed out.
module lf_prefix_adder_pipe
  import lf_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef LF_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L = lf_clog2(WIDTH);

  if (WIDTH < LF_WIDTH_MIN || WIDTH > LF_WIDTH_MAX ||
      PIPE_STAGES < LF_PIPE_MIN || PIPE_STAGES > lf_pipe_max(WIDTH)) begin : g_bad_param
    $error("lf_prefix_adder_pipe: WIDTH or PIPE_STAGES out of range");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is folded into the operands at entry, so the inverted b and
  // forced carry-in ride down the pipe with their own beat.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
`ifdef LF_ADD_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Level 0 forms g/p (cin absorbed into bit 0 so G[i:0] is the carry out of
  // bit i); levels 1..L are the Sklansky-style prefix levels. Each level is
  // either a plain wire or a register boundary.
  for (genvar l = 0; l <= L; l++) begin : lvl
    logic [WIDTH-1:0] g_raw, p_raw, po_raw;
    logic [WIDTH-1:0] g_q, p_q, po_q;
    logic             ci_raw, v_raw;
    logic             ci_q, v_q;

    if (l == 0) begin : g_src
      logic [WIDTH-1:0] g0, p0;
      assign g0     = a & b_eff;
      assign p0     = a ^ b_eff;
      assign g_raw  = {g0[WIDTH-1:1], g0[0] | (p0[0] & cin_eff)};
      assign p_raw  = {p0[WIDTH-1:1], 1'b0};
      assign po_raw = p0;
      assign ci_raw = cin_eff;
      assign v_raw  = in_valid;
    end else begin : g_tree
      localparam int SPAN = 1 << (l - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : bitpos
        if (((i / SPAN) % 2) == 1) begin : g_dot
          // Lower neighbour is the top bit of the lower half-block.
          localparam int LO = (i / SPAN) * SPAN - 1;
          lf_dot u_dot (
            .g_hi  (lvl[l-1].g_q[i]),
            .p_hi  (lvl[l-1].p_q[i]),
            .g_lo  (lvl[l-1].g_q[LO]),
            .p_lo  (lvl[l-1].p_q[LO]),
            .g_out (g_raw[i]),
            .p_out (p_raw[i])
          );
        end else begin : g_pass
          assign g_raw[i] = lvl[l-1].g_q[i];
          assign p_raw[i] = lvl[l-1].p_q[i];
        end
      end
      assign po_raw = lvl[l-1].po_q;
      assign ci_raw = lvl[l-1].ci_q;
      assign v_raw  = lvl[l-1].v_q;
    end

    if (lf_is_boundary(l, L, PIPE_STAGES)) begin : g_reg
      // Boundary register: whole stage advances only with the global enable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          g_q  <= '0;
          p_q  <= '0;
          po_q <= '0;
          ci_q <= 1'b0;
          v_q  <= 1'b0;
        end else if (adv) begin
          g_q  <= g_raw;
          p_q  <= p_raw;
          po_q <= po_raw;
          ci_q <= ci_raw;
          v_q  <= v_raw;
        end
      end
    end else begin : g_wire
      assign g_q  = g_raw;
      assign p_q  = p_raw;
      assign po_q = po_raw;
      assign ci_q = ci_raw;
      assign v_q  = v_raw;
    end
  end

  // Group propagate out of the last level has no consumer.
  logic unused_p;
  assign unused_p = ^lvl[L].p_q;

  logic [WIDTH-1:0] carry;
  assign carry = lvl[L].g_q;

  // Output stage: results only update for a valid beat, so they keep the
  // last delivered values across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= lvl[L].v_q;
      if (lvl[L].v_q) begin
        sum  <= lvl[L].po_q ^ {carry[WIDTH-2:0], lvl[L].ci_q};
        cout <= carry[WIDTH-1];
        ovf  <= carry[WIDTH-1] ^ carry[WIDTH-2];
      end
    end
  end

endmodule

// File: doc/lf_prefix_adder_pipe.md
LF_PREFIX_ADDER_PIPE -- requirements
Module: lf_prefix_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 2..64.
REQ-002 Parameter PIPE_STAGES, default 2, number of register stages from input to output; legal range 1..clog2(WIDTH)+1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  operand beat accepted when in_valid and in_ready are both high.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 cin  input  1  carry-in.
REQ-009 sub  input  1  subtract select; present only with LF_ADD_SUB_EN.
REQ-010 out_valid  output  1  result beat available.
REQ-011 out_ready  input  1  consumer accepts the result beat.
REQ-012 sum  output  WIDTH  result bits.
REQ-013 cout  output  1  carry out of MSB.
REQ-014 ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 Compute {cout,sum} = a + b + cin using a Ladner-Fischer prefix tree: g=a&b, p=a^b, with cin folded in as carry into bit 0; clog2(WIDTH) prefix levels; sum[i]=p[i]^c[i-1], sum[0]=p[0]^cin.
REQ-016 Place pipeline registers after prefix levels floor(k*L/PIPE_STAGES) for k=1..PIPE_STAGES-1, where L=clog2(WIDTH); the final stage registers sum/cout/ovf.
REQ-017 Each stage carries a valid bit; latency from accepted input to out_valid is exactly PIPE_STAGES cycles when not stalled.
REQ-018 Global advance enable adv = !out_valid || out_ready; in_ready = adv; all stages load only when adv is high.
REQ-019 When adv is high, each stage valid bit takes the previous stage valid (stage 0 takes in_valid); bubbles propagate and are not collapsed.
REQ-020 While out_valid=1 and out_ready=0: sum, cout, ovf, out_valid and all internal stages hold unchanged; in_ready=0.
REQ-021 in_valid=1 with in_ready=0 has no effect; a, b, cin and sub are ignored.
REQ-022 Accept and emit in the same cycle (in_valid, in_ready, out_valid, out_ready all high): full throughput of one result per cycle, no bubble inserted.
REQ-023 Data registers of an invalid stage take don't-care values internally; sum/cout/ovf keep their last valid values while out_valid=0.
REQ-024 Wrap-around: the carry out of the MSB appears only on cout; sum is the result modulo 2^WIDTH.

Reset
REQ-025 On rst_n low, all stage valid bits, out_valid, sum, cout and ovf are 0 immediately, independent of clk.
REQ-026 in_ready is 1 throughout reset; beats offered while rst_n is low are discarded.
REQ-027 Reset mid-operation discards all in-flight beats; the first accept after release yields out_valid exactly PIPE_STAGES cycles later.

Configuration
REQ-028 Macro LF_ADD_SUB_EN: when defined, port sub exists and sub=1 computes a + ~b + 1 (cin ignored); ovf uses the same rule; sub is pipelined with its beat.
REQ-029 Without LF_ADD_SUB_EN: port sub is absent and the block performs addition only.

Structure
REQ-030 Shared package lf_pkg holds the clog2 constant function, the stage-boundary level function, and the WIDTH/PIPE_STAGES range constants.
REQ-031 One sub-module lf_dot implements the prefix cell (g_out=g_hi|(p_hi&g_lo), p_out=p_hi&p_lo); it is instantiated by generate loops.

Verification (WIDTH=16, PIPE_STAGES=2 unless stated)
REQ-032 Operands a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0, out_valid 2 cycles after accept.
REQ-033 Operands a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1; with LF_ADD_SUB_EN, a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0, ovf=0.
REQ-034 Ten back-to-back beats with out_ready=1 -> ten results on consecutive cycles, in order; then out_ready=0 for 3 cycles -> outputs held stable, in_ready=0, no beat lost.
REQ-035 rst_n pulsed low while 2 beats are in flight -> out_valid=0 at once, no stale result after release; next beat is emitted at the correct latency.
REQ-036 Random sweep over WIDTH in {2,5,16,64} and all legal PIPE_STAGES, 10^4 beats with random in_valid/out_ready -> every result matches a behavioural a+b+cin model and order is preserved.
